// File: rtl/cpu_clock_controller.sv
// Turns the divided clock (free-run) or a debounced step button (single-step) into a
// one-CLK_IN-cycle CPU clock-enable pulse, with a halt override and a pulse counter.
module cpu_clock_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             CLK_IN,
  input  logic             RESET,
  input  logic             DIV_CLK_IN,
  input  logic             RUN_MODE,
  input  logic             STEP_BTN,
  input  logic             HALT,
  output logic             CPU_CLK_EN,
  output logic [CNT_W-1:0] STEP_COUNT,
  output logic [1:0]       MODE_STATE
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic            div_d1_q;
  logic            div_prev_q;
  logic            tick;

  logic            btn_s1_q;
  logic            btn_s2_q;
  logic            deb_level_q, deb_level_d;
  logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic            step_req_q, step_req_d;

  logic [1:0]      state_q, state_d;
  logic            en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // DIV_CLK_IN is derived from CLK_IN, so one flop is enough before edge detection.
  assign tick = div_d1_q & ~div_prev_q;

  // Debouncer: the level only follows the synced button after an unbroken run of
  // DEBOUNCE_CYCLES disagreeing samples; any agreement restarts the run.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (btn_s2_q != deb_level_q) begin
      if (deb_cnt_q == DB_LAST) begin
        deb_level_d = btn_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DB_W'(1);
      end
    end
    step_req_d = deb_level_d & ~deb_level_q;
  end

  // Priority inside every state: HALT, then RUN_MODE, then step_req.
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (HALT) begin
          state_d = ST_HALTED;
        end else if (RUN_MODE) begin
          state_d = ST_RUN;
        end else if (step_req_q) begin
          state_d = ST_WAIT;
          en_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (HALT) begin
          state_d = ST_HALTED;
        end else if (!RUN_MODE) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          en_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (HALT) begin
          state_d = ST_HALTED;
        end else if (!deb_level_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (!HALT) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign cnt_d = en_d ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      div_d1_q    <= 1'b0;
      div_prev_q  <= 1'b0;
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      deb_level_q <= 1'b0;
      deb_cnt_q   <= '0;
      step_req_q  <= 1'b0;
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      div_d1_q    <= DIV_CLK_IN;
      div_prev_q  <= div_d1_q;
      btn_s1_q    <= STEP_BTN;
      btn_s2_q    <= btn_s1_q;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      step_req_q  <= step_req_d;
      state_q     <= state_d;
      en_q        <= en_d;
      cnt_q       <= cnt_d;
    end
  end

  assign CPU_CLK_EN = en_q;
  assign STEP_COUNT = cnt_q;
  assign MODE_STATE = state_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Scoreboard bench for cpu_clock_controller: expected pulse windows are queued as
// stimulus is driven and retired by a monitor when CPU_CLK_EN is seen high.
module tb_cpu_clock_controller;

  typedef struct {
    int lo;
    int hi;
  } win_t;

  logic        clk;
  logic        rst;
  logic        div_clk;
  logic        run_mode;
  logic        step_btn;
  logic        halt;
  logic        en16;
  logic [15:0] cnt16;
  logic [1:0]  mode16;
  logic        en4;
  logic [3:0]  cnt4;
  logic [1:0]  mode4;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   exp_cnt  = 0;
  bit   prev_en  = 1'b0;
  win_t exp_q[$];

  cpu_clock_controller #(.DEBOUNCE_CYCLES(16), .CNT_W(16)) u_dut (
    .CLK_IN(clk), .RESET(rst), .DIV_CLK_IN(div_clk), .RUN_MODE(run_mode),
    .STEP_BTN(step_btn), .HALT(halt), .CPU_CLK_EN(en16), .STEP_COUNT(cnt16),
    .MODE_STATE(mode16)
  );

  cpu_clock_controller #(.DEBOUNCE_CYCLES(16), .CNT_W(4)) u_dut4 (
    .CLK_IN(clk), .RESET(rst), .DIV_CLK_IN(div_clk), .RUN_MODE(run_mode),
    .STEP_BTN(step_btn), .HALT(halt), .CPU_CLK_EN(en4), .STEP_COUNT(cnt4),
    .MODE_STATE(mode4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every observed pulse must match the oldest queued window.
  initial forever begin
    @(negedge clk);
    if (en16 === 1'b1) begin
      checks++;
      $display("pulse cyc=%0d step_count=%0d mode=%0d", cyc, cnt16, mode16);
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d expected no pulse", cyc);
      end else begin
        win_t w;
        w = exp_q.pop_front();
        if (cyc < w.lo || cyc > w.hi) begin
          failures++;
          $display("FAIL pulse_time got cyc=%0d expected %0d..%0d", cyc, w.lo, w.hi);
        end
      end
      if (prev_en) begin
        failures++;
        $display("FAIL pulse_width high on consecutive cycles at cyc=%0d", cyc);
      end
    end
    prev_en = (en16 === 1'b1);
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int lo, input int hi);
    win_t w;
    w.lo = lo;
    w.hi = hi;
    exp_q.push_back(w);
    exp_cnt++;
  endtask

  task automatic check_mode(input string name, input logic [1:0] exp);
    checks++;
    if (mode16 !== exp) begin
      failures++;
      $display("FAIL %s mode got=%0d expected=%0d", name, mode16, exp);
    end
  endtask

  task automatic check_count(input string name);
    checks++;
    if (cnt16 !== 16'(exp_cnt) || cnt4 !== 4'(exp_cnt)) begin
      failures++;
      $display("FAIL %s count got=%0d/%0d expected=%0d/%0d", name, cnt16, cnt4,
               16'(exp_cnt), 4'(exp_cnt));
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_pulses got=%0d outstanding expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input logic rm);
    rst = 1'b1; run_mode = rm; step_btn = 1'b0; halt = 1'b0; div_clk = 1'b0;
    cyc_wait(2);
    exp_q.delete();
    exp_cnt = 0;
    rst = 1'b0;
  endtask

  // One divided-clock period of 8: pulse expected at the second edge after the rise is driven.
  task automatic free_pulses(input int n, input bit chk_each);
    for (int i = 0; i < n; i++) begin
      expect_pulse(cyc + 2, cyc + 2);
      div_clk = 1'b1;
      cyc_wait(4);
      div_clk = 1'b0;
      cyc_wait(4);
      if (chk_each) check_count("wrap_step");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; run_mode = 1'b1; step_btn = 1'b1; halt = 1'b0; div_clk = 1'b1;
    cyc_wait(3);
    checks++;
    if (en16 !== 1'b0 || cnt16 !== 16'd0 || mode16 !== 2'd0 ||
        en4 !== 1'b0 || cnt4 !== 4'd0 || mode4 !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got en=%b cnt=%0d mode=%0d expected en=0 cnt=0 mode=0",
               en16, cnt16, mode16);
    end
    do_reset(1'b0);
    cyc_wait(2);
    check_mode("reset_idle", 2'd0);
  endtask

  task automatic test_free_run;
    run_mode = 1'b1;
    cyc_wait(2);
    check_mode("free_run_mode", 2'd1);
    free_pulses(10, 1'b0);
    check_count("free_run_count");
    check_drained("free_run");
  endtask

  task automatic test_debounce;
    int a;
    run_mode = 1'b0;
    cyc_wait(2);
    check_mode("debounce_idle", 2'd0);
    for (int i = 0; i < 14; i++) begin
      step_btn = (i % 2 == 0);
      cyc_wait(3);
    end
    step_btn = 1'b1;
    a = cyc;
    expect_pulse(a + 18, a + 20);
    cyc_wait(20);
    check_mode("debounce_wait", 2'd2);
    check_count("debounce_count");
    step_btn = 1'b0;
    cyc_wait(10);
    check_mode("debounce_hold", 2'd2);
    cyc_wait(12);
    check_mode("debounce_release", 2'd0);
    check_drained("debounce");
  endtask

  task automatic test_halt;
    run_mode = 1'b1;
    cyc_wait(2);
    check_mode("halt_run", 2'd1);
    div_clk = 1'b1;
    cyc_wait(1);
    halt = 1'b1;
    cyc_wait(1);
    check_mode("halt_enter", 2'd3);
    check_count("halt_count");
    div_clk = 1'b0; cyc_wait(4);
    div_clk = 1'b1; cyc_wait(4);
    div_clk = 1'b0; cyc_wait(4);
    check_mode("halt_hold", 2'd3);
    check_count("halt_hold_count");
    halt = 1'b0;
    cyc_wait(1);
    check_mode("halt_exit_idle", 2'd0);
    cyc_wait(1);
    check_mode("halt_exit_run", 2'd1);
    free_pulses(2, 1'b0);
    check_count("halt_resume_count");
    check_drained("halt");
  endtask

  task automatic test_wrap;
    do_reset(1'b1);
    cyc_wait(2);
    free_pulses(17, 1'b1);
    checks++;
    if (cnt4 !== 4'd1 || cnt16 !== 16'd17) begin
      failures++;
      $display("FAIL wrap_final got=%0d/%0d expected=1/17", cnt4, cnt16);
    end
    check_drained("wrap");
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    cyc_wait(2);
    step_btn = 1'b1;
    cyc_wait(18);
    rst = 1'b1;
    step_btn = 1'b0;
    cyc_wait(1);
    checks++;
    if (en16 !== 1'b0 || cnt16 !== 16'd0 || mode16 !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid got en=%b cnt=%0d mode=%0d expected en=0 cnt=0 mode=0",
               en16, cnt16, mode16);
    end
    rst = 1'b0;
    cyc_wait(30);
    check_mode("reset_mid_after", 2'd0);
    check_count("reset_mid_count");
    check_drained("reset_mid");
  endtask

  task automatic test_mode_race;
    do_reset(1'b0);
    cyc_wait(2);
    step_btn = 1'b1;
    cyc_wait(18);
    run_mode = 1'b1;
    cyc_wait(1);
    check_mode("race_run", 2'd1);
    cyc_wait(3);
    check_count("race_no_step");
    free_pulses(1, 1'b0);
    check_count("race_tick_count");
    step_btn = 1'b0;
    cyc_wait(20);
    check_mode("race_still_run", 2'd1);
    check_drained("mode_race");
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_debounce();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_mode_race();
    cyc_wait(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
